// File: rtl/desempaquetador_operandos.sv
// desempaquetador_operandos: byte-stream loader that unpacks two binary32
// operands (A then B, big-endian) into significands, exponents and flags.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   din, din_valid       operand byte stream in
//   din_ready            high while loading (LOAD)
//   in1, in2             {hidden, frac} of A and B
//   exp_a, exp_b         raw biased exponents
//   sign_out             sign A xor sign B
//   op_zero/inf/nan      product class, at most one set
//   op_valid, op_ack     pair held stable until ack
module desempaquetador_operandos (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [23:0] in1,
  output logic [23:0] in2,
  output logic [7:0]  exp_a,
  output logic [7:0]  exp_b,
  output logic        sign_out,
  output logic        op_zero,
  output logic        op_inf,
  output logic        op_nan,
  output logic        op_valid,
  input  logic        op_ack
);

  typedef enum logic {
    LOAD = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef struct packed {
    logic [23:0] sig;
    logic [7:0]  exp;
    logic        sgn;
    logic        zero;
    logic        inf;
    logic        nan;
  } unpk_t;

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [7:0]  cap [7];
  logic        accept;
  logic        last;
  logic [31:0] word_a;
  logic [31:0] word_b;
  unpk_t       ua, ub;
  logic        f_nan, f_inf, f_zero;

  // Denormals flush to zero; inf/nan keep the hidden bit set.
  function automatic unpk_t unpack(input logic [31:0] w);
    unpk_t u;
    logic  e_min, e_max, f_nz;
    e_min  = (w[30:23] == 8'h00);
    e_max  = (w[30:23] == 8'hFF);
    f_nz   = |w[22:0];
    u      = '0;
    u.sgn  = w[31];
    u.exp  = w[30:23];
    unique case (1'b1)
      e_min: begin
        u.sig  = 24'd0;
        u.zero = 1'b1;
      end
      e_max: begin
        u.sig = {1'b1, w[22:0]};
        u.inf = ~f_nz;
        u.nan = f_nz;
      end
      default: begin
        u.sig = {1'b1, w[22:0]};
      end
    endcase
    return u;
  endfunction

  assign din_ready = (state == LOAD);
  assign op_valid  = (state == HOLD);
  assign accept    = din_valid & din_ready;
  assign last      = accept & (cnt == 3'd7);

  // Byte 7 is used straight from din on the
  // edge that accepts it.
  assign word_a = {cap[0], cap[1], cap[2], cap[3]};
  assign word_b = {cap[4], cap[5], cap[6], din};

  always_comb begin
    ua     = unpack(word_a);
    ub     = unpack(word_b);
    f_nan  = ua.nan | ub.nan
           | (ua.inf & ub.zero)
           | (ua.zero & ub.inf);
    f_inf  = (ua.inf | ub.inf) & ~f_nan;
    f_zero = (ua.zero | ub.zero) & ~f_nan;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      LOAD: begin
        if (accept) begin
          cnt_nx = cnt + 3'd1;
          if (cnt == 3'd7) state_nx = HOLD;
        end
      end
      HOLD: begin
        if (op_ack) state_nx = LOAD;
      end
      default: begin
        state_nx = LOAD;
        cnt_nx   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      cnt   <= 3'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 7; i++) cap[i] <= 8'd0;
    end else if (accept && cnt != 3'd7) begin
      cap[cnt] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in1      <= 24'd0;
      in2      <= 24'd0;
      exp_a    <= 8'd0;
      exp_b    <= 8'd0;
      sign_out <= 1'b0;
      op_zero  <= 1'b0;
      op_inf   <= 1'b0;
      op_nan   <= 1'b0;
    end else if (last) begin
      in1      <= ua.sig;
      in2      <= ub.sig;
      exp_a    <= ua.exp;
      exp_b    <= ub.exp;
      sign_out <= ua.sgn ^ ub.sgn;
      op_zero  <= f_zero;
      op_inf   <= f_inf;
      op_nan   <= f_nan;
    end
  end

endmodule

// File: tb/tb_desempaquetador_operandos.sv
// tb_desempaquetador_operandos: directed vectors with hand-computed
// expectations for the operand unpacker.
module tb_desempaquetador_operandos;

  logic        clk;
  logic        rst_n;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic [23:0] in1, in2;
  logic [7:0]  exp_a, exp_b;
  logic        sign_out;
  logic        op_zero, op_inf, op_nan;
  logic        op_valid;
  logic        op_ack;

  int checks;
  int errors;

  desempaquetador_operandos dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .in1       (in1),
    .in2       (in2),
    .exp_a     (exp_a),
    .exp_b     (exp_b),
    .sign_out  (sign_out),
    .op_zero   (op_zero),
    .op_inf    (op_inf),
    .op_nan    (op_nan),
    .op_valid  (op_valid),
    .op_ack    (op_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bytes change on negedge; gap = idle cycles between bytes.
  task automatic send_pair(input logic [31:0] a,
                           input logic [31:0] b,
                           input int gap);
    logic [63:0] w;
    w = {a, b};
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        repeat (gap) begin
          @(negedge clk);
          din_valid = 1'b0;
        end
      end
      @(negedge clk);
      din_valid = 1'b1;
      din       = w[63-8*i -: 8];
      if (i == 7) chk("pre_valid", {31'd0, op_valid}, 32'd0);
    end
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag,
                         input logic [23:0] e1,
                         input logic [23:0] e2,
                         input logic [7:0]  ea,
                         input logic [7:0]  eb,
                         input logic        es,
                         input logic [2:0]  ef);
    chk({tag, ".vld"}, {31'd0, op_valid}, 32'd1);
    chk({tag, ".rdy"}, {31'd0, din_ready}, 32'd0);
    chk({tag, ".in1"}, {8'd0, in1}, {8'd0, e1});
    chk({tag, ".in2"}, {8'd0, in2}, {8'd0, e2});
    chk({tag, ".exp"}, {16'd0, exp_a, exp_b}, {16'd0, ea, eb});
    chk({tag, ".sgn"}, {31'd0, sign_out}, {31'd0, es});
    chk({tag, ".flg"}, {29'd0, op_zero, op_inf, op_nan},
        {29'd0, ef});
  endtask

  task automatic release_pair(input string tag);
    op_ack = 1'b1;
    @(negedge clk);
    op_ack = 1'b0;
    chk({tag, ".rel_vld"}, {31'd0, op_valid}, 32'd0);
    chk({tag, ".rel_rdy"}, {31'd0, din_ready}, 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".rdy"}, {31'd0, din_ready}, 32'd1);
    chk({tag, ".vld"}, {31'd0, op_valid}, 32'd0);
    chk({tag, ".in"}, {in1[7:0], in2}, 32'd0);
    chk({tag, ".hi"}, {16'd0, in1[23:8]}, 32'd0);
    chk({tag, ".exp"}, {16'd0, exp_a, exp_b}, 32'd0);
    chk({tag, ".flg"},
        {28'd0, sign_out, op_zero, op_inf, op_nan}, 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    din       = 8'd0;
    din_valid = 1'b0;
    op_ack    = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // 1.5 x -2.5
    send_pair(32'h3FC00000, 32'hC0200000, 0);
    chk_out("basic", 24'hC00000, 24'hA00000,
            8'h7F, 8'h80, 1'b1, 3'b000);
    release_pair("basic");
    chk("basic.keep", {8'd0, in1}, 32'h00C00000);

    // denormal flushes to zero
    send_pair(32'h00000001, 32'h40000000, 0);
    chk_out("denorm", 24'h000000, 24'h800000,
            8'h00, 8'h80, 1'b0, 3'b100);
    release_pair("denorm");

    // inf x 0
    send_pair(32'h7F800000, 32'h00000000, 0);
    chk_out("infz", 24'h800000, 24'h000000,
            8'hFF, 8'h00, 1'b0, 3'b001);
    release_pair("infz");

    // inf x 1.0
    send_pair(32'h7F800000, 32'h3F800000, 0);
    chk_out("inf1", 24'h800000, 24'h800000,
            8'hFF, 8'h7F, 1'b0, 3'b010);
    release_pair("inf1");

    // qNaN x 1.0
    send_pair(32'h7FC00000, 32'h3F800000, 0);
    chk_out("nan", 24'hC00000, 24'h800000,
            8'hFF, 8'h7F, 1'b0, 3'b001);

    // backpressure: held in HOLD while din_valid high
    din       = 8'h40;
    din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.rdy", {31'd0, din_ready}, 32'd0);
      chk("bp.in1", {8'd0, in1}, 32'h00C00000);
    end
    chk_out("bp.hold", 24'hC00000, 24'h800000,
            8'hFF, 8'h7F, 1'b0, 3'b001);
    din_valid = 1'b0;
    release_pair("bp");
    // -2.0 x -4.0
    send_pair(32'hC0000000, 32'hC0800000, 0);
    chk_out("bp.next", 24'h800000, 24'h800000,
            8'h80, 8'h81, 1'b0, 3'b000);
    release_pair("bp.next");

    // gaps: valid pattern 1,0,0,1,...
    send_pair(32'h3FC00000, 32'hC0200000, 2);
    chk_out("gap", 24'hC00000, 24'hA00000,
            8'h7F, 8'h80, 1'b1, 3'b000);
    release_pair("gap");

    // ack tied high: single-cycle HOLD
    op_ack = 1'b1;
    send_pair(32'h40400000, 32'h3F000000, 0);
    chk("tput.vld", {31'd0, op_valid}, 32'd1);
    chk("tput.in1", {8'd0, in1}, 32'h00C00000);
    @(negedge clk);
    chk("tput.drop", {31'd0, op_valid}, 32'd0);
    chk("tput.rdy", {31'd0, din_ready}, 32'd1);
    op_ack = 1'b0;

    // reset after 5 bytes of a pair
    din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = 8'h11 * (i + 1);
      @(negedge clk);
    end
    din_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("rstmid");
    @(negedge clk);
    rst_n = 1'b1;
    send_pair(32'h3FC00000, 32'hC0200000, 0);
    chk_out("rstmid.pair", 24'hC00000, 24'hA00000,
            8'h7F, 8'h80, 1'b1, 3'b000);
    release_pair("rstmid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/desempaquetador_operandos.md
# desempaquetador_operandos

Operand loader that sits directly upstream of the `multiplicador` block. It accepts two IEEE-754 single-precision operands as a byte stream over a valid/ready handshake and unpacks them into 24-bit significands with the hidden bit, raw exponents, a result sign and special-case flags. It holds the unpacked pair stable for the multiplier until that pair is acknowledged.

## Interface
- Parameters: none (format fixed to IEEE-754 binary32, 8-bit byte input).
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  8  operand byte.
- `din_valid`  in  1  `din` holds a byte.
- `din_ready`  out  1  block can accept a byte.
- `in1`  out  24  significand of A, `{hidden, frac[22:0]}`; feeds `multiplicador.in1`.
- `in2`  out  24  significand of B; feeds `multiplicador.in2`.
- `exp_a`, `exp_b`  out  8 each  raw biased exponents.
- `sign_out`  out  1  sign of A XOR sign of B.
- `op_zero`  out  1  product is zero.
- `op_inf`  out  1  product is infinite.
- `op_nan`  out  1  product is NaN.
- `op_valid`  out  1  unpacked pair is valid and stable.
- `op_ack`  in  1  consumer has taken the pair.

## Operation
- **States:**
  - `LOAD`: `din_ready=1`; holds a 3-bit byte counter.
  - `HOLD`: `din_ready=0`, `op_valid=1`.
- **Byte acceptance:** a byte is accepted on a rising edge where `din_valid & din_ready`. Gaps in `din_valid` are allowed and the counter simply waits.
- **Byte order:** big-endian, operand A first.
  - Bytes 0–3 form A, with byte 0 = A[31:24].
  - Bytes 4–7 form B.
- **LOAD → HOLD:** on the edge that accepts byte 7, all output registers load from the captured bytes plus the incoming byte. The counter returns to 0.
- **HOLD → LOAD:** on any edge with `op_ack=1`. Outputs keep their values; only `op_valid` drops.
- **Unpack, per operand:**
  - exp==0: significand=0, zero. Denormals are flushed to zero.
  - exp 1..254: significand=`{1'b1, frac}`.
  - exp==255, frac==0: inf, significand=`{1'b1, frac}`.
  - exp==255, frac!=0: nan, significand=`{1'b1, frac}`.
- **Flags:**
  - `op_nan` = nan_a | nan_b | (inf_a & zero_b) | (zero_a & inf_b).
  - `op_inf` = (inf_a | inf_b) & ~op_nan.
  - `op_zero` = (zero_a | zero_b) & ~op_nan.
  - At most one flag is set.
- **Output stability:** `in1`, `in2`, `exp_*`, `sign_out` and the flags change only on the LOAD→HOLD edge.
- **`op_ack` outside HOLD:** ignored while in LOAD.
- **`din_valid` in HOLD:** ignored; no byte is consumed.
- **Reset (any time, including mid-load or in HOLD):**
  - State goes to LOAD, counter to 0.
  - Partially captured bytes are discarded.
  - All data outputs and flags go to 0, `op_valid=0`, `din_ready=1`.
  - The first byte after release is byte 0 of A.

## Timing
- **Reset values:** `din_ready=1`, `op_valid=0`, `in1=in2=0`, `exp_a=exp_b=0`, `sign_out=0`, `op_zero=op_inf=op_nan=0`.
- **Output timing:** `din_ready` and `op_valid` are decoded from the state register, with no combinational path from inputs.
- **Latency:** if byte 7 is accepted at edge N, then `op_valid=1` and valid data appear after edge N.
- **Release:** if `op_ack` is sampled high at edge M in HOLD, then `op_valid=0` and `din_ready=1` after edge M. The earliest next byte 0 is accepted at edge M+1.
- **Throughput:** minimum 9 cycles per operand pair (8 LOAD + 1 HOLD) when the input is back-to-back and `op_ack` is tied high.

## Test plan
- **Basic unpack:** A=0x3FC00000 (1.5), B=0xC0200000 (−2.5), bytes back-to-back → one cycle after byte 7:
  - `in1=0xC00000`, `in2=0xA00000`
  - `exp_a=0x7F`, `exp_b=0x80`
  - `sign_out=1`, all flags 0.
- **Denormal and zero:** A=0x00000001, B=0x40000000 → `in1=0`, `in2=0x800000`, `op_zero=1`, `op_inf=0`, `op_nan=0`.
- **Special cases:**
  - A=0x7F800000, B=0x00000000 → `op_nan=1`, `op_inf=0`, `op_zero=0`.
  - A=0x7F800000, B=0x3F800000 → `op_inf=1`.
  - A=0x7FC00000 → `op_nan=1`.
- **Backpressure:** hold `op_ack=0` for 5 cycles after `op_valid` while driving `din_valid=1` with the next pair →
  - `din_ready=0`, no byte consumed, outputs unchanged.
  - After `op_ack`, the next pair loads correctly, starting with its byte 0.
- **Input gaps:** `din_valid` toggling 1,0,0,1,… across the 8 bytes → same result as back-to-back; `op_valid` asserts one cycle after the 8th accepted byte.
- **Reset mid-load:** assert `rst_n=0` asynchronously after 5 bytes, then release and send a fresh pair (1.5, −2.5) → reset values appear immediately on assertion, and the pair decodes exactly as in the basic-unpack scenario.
